// File: rtl/divu_arbiter_pkg.sv
// Shared types and constants for the divider arbiter.
// Imported by the interface users, the arbiter and the bench.
package divu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_e;

    localparam int DIVU_ITER = 32;
    localparam int DIVU_DW   = 32;

    // Matches what the divider itself returns for x / 0
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/divu_arbiter_if.sv
// Requester-side request/response bundle for the divider arbiter.
// master = requesters, slave = arbiter.
interface divu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_dividend;
    logic [NUM_REQ*DW-1:0] req_divisor;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [DW-1:0]         resp_quotient;
    logic [DW-1:0]         resp_remainder;

    modport master (
        output req_valid, req_dividend, req_divisor, resp_ready,
        input  req_ready, resp_valid, resp_quotient, resp_remainder
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, resp_ready,
        output req_ready, resp_valid, resp_quotient, resp_remainder
    );
endinterface

// File: rtl/divu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches last+1, last+2, ...
// modulo N and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    int   pos;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last) + k) % N;
            if (!found && req[pos]) begin
                found      = 1'b1;
                gnt[pos]   = 1'b1;
                gnt_idx    = IW'(pos);
            end
        end
    end
endmodule

// File: rtl/divu_arbiter.sv
// Shares one iterative 32-bit unsigned divider among NUM_REQ requesters,
// round-robin, with zero-divisor requests answered without a launch.
module divu_arbiter
    import divu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = DIVU_DW
) (
    input  logic            clk_in,
    input  logic            reset,
    divu_arbiter_if.slave   bus,
    output logic [2*DW-1:0] div_input_data,
    output logic            div_enable,
    input  logic [2*DW-1:0] div_out_data,
    input  logic            div_busy
);
    localparam int IW = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [IW-1:0]      last_q, idx_q, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [DW-1:0]      dividend_q, divisor_q;
    logic [DW-1:0]      quot_q, rem_q;
    logic [DW-1:0]      sel_dividend, sel_divisor;
    logic               accept;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (bus.req_valid),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign sel_dividend = bus.req_dividend[gnt_idx*DW +: DW];
    assign sel_divisor  = bus.req_divisor[gnt_idx*DW +: DW];
    assign accept       = (state_q == IDLE) && (|gnt);

    // Outputs are gated by reset so they drop the instant it rises
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        div_enable     = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = reset ? '0 : gnt;
                if (accept)
                    state_d = (sel_divisor == '0) ? RESP : LAUNCH;
            end
            LAUNCH: begin
                div_enable = !reset;
                state_d    = WAIT;
            end
            WAIT: begin
                if (!div_busy)
                    state_d = RESP;
            end
            RESP: begin
                bus.resp_valid[idx_q] = !reset;
                if (bus.resp_ready[idx_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= IW'(NUM_REQ - 1);
            idx_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q      <= gnt_idx;
                last_q     <= gnt_idx;
                dividend_q <= sel_dividend;
                divisor_q  <= sel_divisor;
                if (sel_divisor == '0) begin
                    quot_q <= DIV0_QUOT;
                    rem_q  <= sel_dividend;
                end
            end
            if (state_q == WAIT && !div_busy) begin
                quot_q <= div_out_data[2*DW-1:DW];
                rem_q  <= div_out_data[DW-1:0];
            end
        end
    end

    // Operand register feeds the divider so it stays fixed mid-divide
    assign div_input_data     = {dividend_q, divisor_q};
    assign bus.resp_quotient  = quot_q;
    assign bus.resp_remainder = rem_q;
endmodule

// File: doc/divu_arbiter.md
# divu_arbiter

Round-robin controller that shares one 32-bit iterative unsigned divider (`unsign_divu`) among `NUM_REQ` requesters. It accepts divide requests with a valid/ready handshake, holds the selected operands stable on the divider input, and pulses the divider enable. It then waits for the divider to finish and returns quotient and remainder to the granted requester. Divide-by-zero requests are short-circuited. The block sits between execute-stage requesters (for example the integer pipeline and a coprocessor port) and the single divider instance.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `DW`, default 32: operand width. Fixed to the divider width; only 32 is supported.
- `clk_in` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `req_valid` in NUM_REQ: request pending, one bit per requester. Once raised, it must stay high until accepted.
- `req_ready` out NUM_REQ: one-hot accept. A request is accepted in the cycle where `req_valid[i] & req_ready[i]`.
- `req_dividend` in NUM_REQ*DW: packed dividends; requester i uses bits [i*DW +: DW].
- `req_divisor` in NUM_REQ*DW: packed divisors, same packing.
- `resp_valid` out NUM_REQ: one-hot result valid for the owning requester.
- `resp_ready` in NUM_REQ: result consumed when `resp_valid[i] & resp_ready[i]`.
- `resp_quotient` out DW: shared result bus.
- `resp_remainder` out DW: shared result bus.
- `div_input_data` out 64: {dividend, divisor} to the divider.
- `div_enable` out 1: one-cycle launch pulse.
- `div_out_data` in 64: {quotient, remainder} from the divider.
- `div_busy` in 1: divider iterating.

## Operation
- States:
  - IDLE: arbitrate among `req_valid`. On accept, latch index, dividend and divisor. If divisor == 0, go to RESP; otherwise go to LAUNCH.
  - LAUNCH: drive `div_enable`=1 for exactly this cycle, then go to WAIT.
  - WAIT: when `div_busy`=0, capture `div_out_data[63:32]` as quotient and `div_out_data[31:0]` as remainder, then go to RESP.
  - RESP: assert `resp_valid[idx]`. When `resp_ready[idx]`, go to IDLE.
- Arbitration:
  - Round-robin. The pointer `last` holds the index of the last accepted requester.
  - Search order is last+1, last+2, … with wrap modulo NUM_REQ.
  - On reset, `last`=NUM_REQ-1, so requester 0 wins first.
  - `req_ready` is nonzero only in IDLE, has at most one bit set, and is set only for a valid requester.
- `div_input_data` is driven from the latched operand register from LAUNCH through WAIT and held constant. The divider re-reads the divisor every iteration, so it must not change mid-divide. `div_input_data` is 0 in IDLE after reset.
- Divide by zero: the result is quotient 0xFFFFFFFF and remainder = dividend, which is identical to the divider's own result. The divider is not launched.
- Reset mid-operation: the state returns to IDLE, and `resp_valid`, `req_ready` and `div_enable` drop immediately. The divider's synchronous reset shares the `reset` net. A stale `div_busy` is ignored outside WAIT.
- `div_busy`=1 observed in IDLE or RESP is a protocol error. It is ignored, and no launch happens until WAIT.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_quotient`=0, `resp_remainder`=0, `div_enable`=0, `div_input_data`=0, state IDLE, `last`=NUM_REQ-1.
- Normal divide, with accept in cycle T:
  - `div_enable` is high in T+1.
  - `div_busy` is high in T+2..T+33 (32 iterations).
  - Result is captured at the end of T+34.
  - `resp_valid` is high from T+35. Latency from accept to `resp_valid` is 35 cycles.
- Zero divisor: `resp_valid` is high from T+1.
- `resp_valid` and the result buses hold until `resp_ready`. The earliest next accept is the cycle after the handshake, so throughput is one request per 36 cycles with `resp_ready` tied high.
- `req_ready` is combinational from `req_valid` and state. `req_valid` must not depend on `req_ready`.

## Structure
- Package `divu_ctrl_pkg` holds:
  - the state enum (IDLE, LAUNCH, WAIT, RESP);
  - `DIVU_ITER`=32;
  - `DIVU_DW`=32;
  - the divide-by-zero quotient constant 32'hFFFF_FFFF.
- Sub-module `rr_arbiter`: parameter N; inputs `req` and `last` pointer; outputs one-hot `gnt` and encoded `gnt_idx`. It is purely combinational. The pointer register lives in `divu_arbiter`.
- The divider is instantiated at the level above and is not inside this block.

## Test plan
- Single request from requester 0, 100 / 7: accepted in T. Expect `div_enable` in T+1, then `resp_valid[0]` in T+35 with quotient 14 and remainder 2.
- Requesters 0 and 1 both valid continuously, `resp_ready` high: grant order is 0,1,0,1. Each response goes to the correct requester with its own operands, for example 0xFFFFFFFF / 0x10 → 0x0FFFFFFF rem 0xF.
- Divisor 0, dividend 0x1234: expect `resp_valid` at T+1 with quotient 0xFFFFFFFF and remainder 0x1234, and `div_enable` never asserted.
- `resp_ready` held low for 10 cycles in RESP: result is stable, `req_ready` stays 0, and no new launch occurs. Accept resumes the cycle after `resp_ready`.
- Assert `reset` during WAIT at iteration 15: all outputs are 0 asynchronously. A new request afterward completes correctly, e.g. 1000 / 10 → 100 rem 0.
- Check `div_input_data` is constant from LAUNCH until WAIT exit while other requesters change their operand buses every cycle.
